// File: rtl/alu_ctrl_pkg.sv
// Op-class and control-code tables, FSM encoding and the combinational
// {ALUOp,funct} decoder shared by the ALU control sequencer.
package alu_ctrl_pkg;

  localparam int DEC_FUNCT_W = 10;
  localparam int DEC_ALUOP_W = 3;
  localparam int DEC_CTRL_W  = 4;

  localparam logic [DEC_ALUOP_W-1:0] ALUOP_LOAD   = 3'b000;
  localparam logic [DEC_ALUOP_W-1:0] ALUOP_ITYPE  = 3'b001;
  localparam logic [DEC_ALUOP_W-1:0] ALUOP_STORE  = 3'b010;
  localparam logic [DEC_ALUOP_W-1:0] ALUOP_RTYPE  = 3'b011;
  localparam logic [DEC_ALUOP_W-1:0] ALUOP_BRANCH = 3'b110;

  localparam logic [DEC_CTRL_W-1:0] CTRL_AND     = 4'b0000;
  localparam logic [DEC_CTRL_W-1:0] CTRL_XOR     = 4'b0001;
  localparam logic [DEC_CTRL_W-1:0] CTRL_SLL     = 4'b0010;
  localparam logic [DEC_CTRL_W-1:0] CTRL_ADD     = 4'b0011;
  localparam logic [DEC_CTRL_W-1:0] CTRL_SUB     = 4'b0100;
  localparam logic [DEC_CTRL_W-1:0] CTRL_MUL     = 4'b0101;
  localparam logic [DEC_CTRL_W-1:0] CTRL_ADDI    = 4'b0110;
  localparam logic [DEC_CTRL_W-1:0] CTRL_SRAI    = 4'b0111;
  localparam logic [DEC_CTRL_W-1:0] CTRL_LW      = 4'b1000;
  localparam logic [DEC_CTRL_W-1:0] CTRL_SW      = 4'b1001;
  localparam logic [DEC_CTRL_W-1:0] CTRL_BEQ     = 4'b1010;
  localparam logic [DEC_CTRL_W-1:0] CTRL_OR      = 4'b1011;
  localparam logic [DEC_CTRL_W-1:0] CTRL_DIV     = 4'b1100;
  localparam logic [DEC_CTRL_W-1:0] CTRL_DIVU    = 4'b1101;
  localparam logic [DEC_CTRL_W-1:0] CTRL_REM     = 4'b1110;
  localparam logic [DEC_CTRL_W-1:0] CTRL_REMU    = 4'b1111;
  localparam logic [DEC_CTRL_W-1:0] CTRL_ILLEGAL = 4'b0000;

  typedef enum logic [1:0] {CLS_BASE, CLS_MUL, CLS_DIV} op_cls_e;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  typedef struct packed {
    logic                  illegal;
    op_cls_e               cls;
    logic [DEC_CTRL_W-1:0] code;
  } dec_t;

  function automatic dec_t decode_ctrl(input logic [DEC_ALUOP_W-1:0] aluop,
                                       input logic [DEC_FUNCT_W-1:0] funct);
    dec_t d;
    d.illegal = 1'b0;
    d.cls     = CLS_BASE;
    d.code    = CTRL_ILLEGAL;
    case (aluop)
      ALUOP_RTYPE: begin
        case (funct)
          10'b0000000111: d.code = CTRL_AND;
          10'b0000000100: d.code = CTRL_XOR;
          10'b0000000001: d.code = CTRL_SLL;
          10'b0000000000: d.code = CTRL_ADD;
          10'b0100000000: d.code = CTRL_SUB;
          10'b0000000110: d.code = CTRL_OR;
          10'b0000001000: begin d.code = CTRL_MUL;  d.cls = CLS_MUL; end
          10'b0000001100: begin d.code = CTRL_DIV;  d.cls = CLS_DIV; end
          10'b0000001101: begin d.code = CTRL_DIVU; d.cls = CLS_DIV; end
          10'b0000001110: begin d.code = CTRL_REM;  d.cls = CLS_DIV; end
          10'b0000001111: begin d.code = CTRL_REMU; d.cls = CLS_DIV; end
          default:        d.illegal = 1'b1;
        endcase
      end
      // I-type ADDI only looks at funct3; SRAI needs funct7 to tell it from SRLI
      ALUOP_ITYPE: begin
        if (funct[2:0] == 3'b000)           d.code = CTRL_ADDI;
        else if (funct == 10'b0100000101)   d.code = CTRL_SRAI;
        else                                d.illegal = 1'b1;
      end
      ALUOP_LOAD: begin
        if (funct[2:0] == 3'b010) d.code = CTRL_LW;
        else                      d.illegal = 1'b1;
      end
      ALUOP_STORE: begin
        if (funct[2:0] == 3'b010) d.code = CTRL_SW;
        else                      d.illegal = 1'b1;
      end
      ALUOP_BRANCH: begin
        if (funct == 10'b0000001000) d.code = CTRL_BEQ;
        else                         d.illegal = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_cnt.sv
// Loadable down-counter pacing the multi-cycle MUL/DIV sequence; parks at zero.
module alu_ctrl_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                         cnt_d = '0;
    else if (load_i)                   cnt_d = load_val_i;
    else if (en_i && (cnt_q != '0))    cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU/MDU control decoder: single-cycle ops issue next cycle,
// MUL/DIV class ops are sequenced by a down-counter while busy_o stalls upstream.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W    = 10,
  parameter int ALUOP_W    = 3,
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic               flush_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  output logic [CTRL_W-1:0]  ALUCtrl_o,
  output logic               ctrl_valid_o,
  output logic               mdu_start_o,
  output logic               busy_o,
  output logic               illegal_o
);

  localparam bit               MUL_MULTI = (MUL_CYCLES > 1);
  localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MUL_MULTI ? MUL_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);

  state_e            state_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              ctrl_valid_q, start_q, busy_q, illegal_q;

  dec_t              dec;
  logic              free, accept, is_mul, is_div;
  logic              cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0]  cnt_load_val;

  always_comb begin
    dec          = decode_ctrl(DEC_ALUOP_W'(ALUOp_i), DEC_FUNCT_W'(funct_i));
    is_mul       = (dec.cls == CLS_MUL) && MUL_MULTI;
    is_div       = (dec.cls == CLS_DIV);
    free         = (state_q == S_IDLE) || (state_q == S_DONE);
    accept       = free && valid_i && !flush_i;
    cnt_load     = accept && (is_mul || is_div);
    cnt_load_val = is_mul ? MUL_LOAD : DIV_LOAD;
    cnt_en       = (state_q == S_MUL) || (state_q == S_DIV);
  end

  alu_ctrl_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (flush_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      ctrl_q       <= '0;
      ctrl_valid_q <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      illegal_q    <= 1'b0;
    end else if (flush_i) begin
      // The killed op never produces a DONE pulse; ALUCtrl_o keeps its last value
      state_q      <= S_IDLE;
      ctrl_valid_q <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      start_q      <= 1'b0;
      ctrl_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (valid_i) begin
            ctrl_q <= CTRL_W'(dec.code);
            if (is_mul || is_div) begin
              start_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= is_mul ? S_MUL : S_DIV;
            end else begin
              ctrl_valid_q <= 1'b1;
              illegal_q    <= dec.illegal;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (cnt_zero) begin
            state_q      <= S_DONE;
            busy_q       <= 1'b0;
            ctrl_valid_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ALUCtrl_o    = ctrl_q;
  assign ctrl_valid_o = ctrl_valid_q;
  assign mdu_start_o  = start_q;
  assign busy_o       = busy_q;
  assign illegal_o    = illegal_q;

endmodule
